usb_ep0_in_streamer: RTL and testbench

Control-endpoint IN data-stage engine between the setup-request decoder and the `usb` core's transmit side. Given a descriptor start address and lengths from a decoded GET_DESCRIPTOR or GET_STATUS, it reads the descriptor ROM and streams bytes to the core in max-packet-sized chunks across successive IN transactions. It manages DATA0/DATA1 toggling, retransmits a packet the host did not ACK, and appends a zero-length packet (ZLP) when required. This replaces the single-packet static-data path.

---
 rtl/usb_pkg.sv | 35 +++
 rtl/usb_ep0_in_streamer.sv | 223 ++++++++++++++++++++++
 tb/tb_usb_ep0_in_streamer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB device definitions: handshake codes, descriptor ROM offsets,
// the EP0 packet-size default and the EP0 IN data-stage state encoding.
package usb_pkg;

  // Default EP0 max packet size in bytes (power of two, 8..64).
  localparam int EP0_MAX_PKT = 8;

  // Handshake codes exchanged with the usb core.
  typedef enum logic [1:0] {
    hs_ack   = 2'b00,
    hs_none  = 2'b01,
    hs_nak   = 2'b10,
    hs_stall = 2'b11
  } usb_hs_t;

  // Descriptor ROM layout shared with the setup decoder.
  localparam logic [7:0] DESC_DEVICE_OFS  = 8'd0;
  localparam logic [7:0] DESC_DEVICE_LEN  = 8'd18;
  localparam logic [7:0] DESC_CONFIG_OFS  = 8'd18;
  localparam logic [7:0] DESC_CONFIG_LEN  = 8'd25;
  localparam logic [7:0] DESC_STRING0_OFS = 8'd43;
  localparam logic [7:0] DESC_STRING0_LEN = 8'd4;
  localparam logic [7:0] DESC_STATUS_OFS  = 8'd47;
  localparam logic [7:0] DESC_STATUS_LEN  = 8'd2;

  // EP0 IN data-stage states.
  typedef enum logic [2:0] {
    st_idle     = 3'd0,
    st_armed    = 3'd1,
    st_load     = 3'd2,
    st_send     = 3'd3,
    st_wait_ack = 3'd4
  } ep0_state_t;

endpackage

// File: rtl/usb_ep0_in_streamer.sv
// EP0 IN data-stage engine: streams a descriptor from the external ROM to
// the usb core in max-packet chunks, handles DATA0/DATA1 toggling, resends
// un-ACKed packets and appends a zero-length packet when the host asked
// for more than the descriptor holds and it ends on a packet boundary.
module usb_ep0_in_streamer
  import usb_pkg::*;
#(
  parameter int MAX_PKT = EP0_MAX_PKT,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        req_len,
  input  logic [7:0]        desc_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              transaction_active,
  input  logic              direction_in,
  input  logic              data_strobe,
  input  logic              success,
  output logic [7:0]        data_in,
  output logic              data_in_valid,
  output logic              data_toggle,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0]        max_pkt_c  = 8'(MAX_PKT);
  localparam logic [7:0]        pkt_mask_c = 8'(MAX_PKT - 1);
  localparam logic [ADDR_W-1:0] addr_one_c = ADDR_W'(1);

  ep0_state_t        state_r;
  logic [ADDR_W-1:0] base_r;
  logic [7:0]        total_r;
  logic [7:0]        sent_r;
  logic [7:0]        pkt_len_r;
  logic [7:0]        idx_r;
  logic              zlp_r;       // a ZLP is still owed after the data
  logic              zlp_pkt_r;   // the packet in flight is the ZLP
  logic              pend_r;      // ROM still fetching the next byte
  logic              ta_prev_r;
  logic              success_seen_r;

  logic              ta_rise_s;
  logic              ta_fall_s;
  logic [7:0]        start_total_s;
  logic              start_zlp_s;
  logic [7:0]        remain_s;
  logic [7:0]        next_len_s;
  logic              acked_s;
  logic [7:0]        sent_acked_s;
  logic              finish_s;

  // Edge detection, start-parameter math and end-of-transaction decision.
  always_comb begin
    ta_rise_s     = transaction_active & ~ta_prev_r;
    ta_fall_s     = ~transaction_active & ta_prev_r;
    start_total_s = desc_len;
    next_len_s    = max_pkt_c;
    if (req_len < desc_len) begin
      start_total_s = req_len;
    end else begin
      start_total_s = desc_len;
    end
    start_zlp_s = (start_total_s < req_len) &&
                  ((start_total_s & pkt_mask_c) == 8'd0) &&
                  (start_total_s != 8'd0);
    remain_s = total_r - sent_r;
    if (remain_s == 8'd0) begin
      next_len_s = 8'd0;
    end else if (remain_s < max_pkt_c) begin
      next_len_s = remain_s;
    end else begin
      next_len_s = max_pkt_c;
    end
    acked_s      = success_seen_r | success;
    sent_acked_s = sent_r + pkt_len_r;
    finish_s     = acked_s && (sent_acked_s == total_r) && !(zlp_r && !zlp_pkt_r);
  end

  // Track transaction_active history and whether the host ACKed this transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ta_prev_r      <= 1'b0;
      success_seen_r <= 1'b0;
    end else if (abort) begin
      ta_prev_r      <= transaction_active;
      success_seen_r <= 1'b0;
    end else begin
      ta_prev_r <= transaction_active;
      if (ta_rise_s) begin
        success_seen_r <= success;
      end else if (transaction_active && success) begin
        success_seen_r <= 1'b1;
      end else begin
        success_seen_r <= success_seen_r;
      end
    end
  end

  // Data-stage state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      state_r       <= st_idle;
      rom_addr      <= '0;
      data_in       <= 8'd0;
      data_in_valid <= 1'b0;
      data_toggle   <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      base_r        <= '0;
      total_r       <= 8'd0;
      sent_r        <= 8'd0;
      pkt_len_r     <= 8'd0;
      idx_r         <= 8'd0;
      zlp_r         <= 1'b0;
      zlp_pkt_r     <= 1'b0;
      pend_r        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        total_r       <= start_total_s;
        zlp_r         <= start_zlp_s;
        base_r        <= start_addr;
        sent_r        <= 8'd0;
        data_toggle   <= 1'b1;
        data_in_valid <= 1'b0;
        idx_r         <= 8'd0;
        pend_r        <= 1'b0;
        if (start_total_s == 8'd0) begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= st_idle;
        end else begin
          busy    <= 1'b1;
          state_r <= st_armed;
        end
      end else begin
        case (state_r)
          st_idle: begin
            state_r <= st_idle;
          end
          st_armed: begin
            if (ta_rise_s && direction_in) begin
              pkt_len_r <= next_len_s;
              zlp_pkt_r <= (sent_r == total_r);
              rom_addr  <= base_r + ADDR_W'(sent_r);
              idx_r     <= 8'd0;
              pend_r    <= 1'b0;
              state_r   <= st_load;
            end else if (ta_rise_s) begin
              // OUT token here is the status stage: the host is finished.
              busy    <= 1'b0;
              state_r <= st_idle;
            end else begin
              state_r <= st_armed;
            end
          end
          st_load: begin
            if (ta_fall_s) begin
              state_r <= st_armed;
            end else begin
              state_r <= st_send;
            end
          end
          st_send: begin
            if (ta_fall_s) begin
              // Transaction ended early: resend the same packet.
              data_in_valid <= 1'b0;
              state_r       <= st_armed;
            end else if (idx_r == pkt_len_r) begin
              data_in_valid <= 1'b0;
              state_r       <= st_wait_ack;
            end else if (data_strobe && data_in_valid) begin
              idx_r         <= idx_r + 8'd1;
              rom_addr      <= rom_addr + addr_one_c;
              data_in_valid <= 1'b0;
              pend_r        <= 1'b1;
            end else if (pend_r) begin
              pend_r <= 1'b0;
            end else begin
              data_in       <= rom_data;
              data_in_valid <= 1'b1;
            end
          end
          st_wait_ack: begin
            if (ta_fall_s) begin
              if (acked_s) begin
                sent_r      <= sent_acked_s;
                data_toggle <= ~data_toggle;
                if (zlp_pkt_r) begin
                  zlp_r <= 1'b0;
                end else begin
                  zlp_r <= zlp_r;
                end
              end else begin
                sent_r <= sent_r;
              end
              if (finish_s) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                state_r <= st_idle;
              end else begin
                state_r <= st_armed;
              end
            end else begin
              state_r <= st_wait_ack;
            end
          end
          default: begin
            data_in_valid <= 1'b0;
            busy          <= 1'b0;
            state_r       <= st_idle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_ep0_in_streamer.sv
// Self-checking bench for usb_ep0_in_streamer: a ROM model, a usb-core
// transaction driver and a byte scoreboard fed from a reference model.
module tb_usb_ep0_in_streamer;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] start_addr, req_len, desc_len;
  logic [7:0] rom_addr, rom_data;
  logic       transaction_active, direction_in, data_strobe, success;
  logic [7:0] data_in;
  logic       data_in_valid, data_toggle, busy, done;

  usb_ep0_in_streamer #(.MAX_PKT(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_addr(start_addr), .req_len(req_len), .desc_len(desc_len),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .transaction_active(transaction_active), .direction_in(direction_in),
    .data_strobe(data_strobe), .success(success),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_toggle(data_toggle), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];

  // reference model of the data stage
  int m_base, m_total, m_sent, m_tog;
  bit m_zlp;

  typedef struct {
    int addr;
    int req;
    int desc;
    int exp_pkts;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input int addr, input int req, input int desc);
    @(negedge clk);
    start = 1'b1; start_addr = 8'(addr); req_len = 8'(req); desc_len = 8'(desc);
    @(negedge clk);
    start = 1'b0;
    m_total = (req < desc) ? req : desc;
    m_zlp   = (m_total < req) && (m_total % 8 == 0) && (m_total != 0);
    m_sent  = 0;
    m_tog   = 1;
    m_base  = addr;
  endtask

  // One IN transaction: consume the packet, optionally ACK, then end it.
  task automatic in_txn(input bit ack, output bit dut_done);
    int len;
    bit exp_done;
    logic [7:0] exp_b;
    len = (m_sent == m_total) ? 0 : (((m_total - m_sent) < 8) ? (m_total - m_sent) : 8);
    for (int i = 0; i < len; i++) sb_q.push_back(rom_mem[(m_base + m_sent + i) & 255]);
    transaction_active = 1'b1; direction_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      int w = 0;
      while (!data_in_valid && w < 12) begin
        @(negedge clk);
        w++;
      end
      if (!data_in_valid) begin
        check("byte_timeout", 0, 1);
        break;
      end
      exp_b = sb_q.pop_front();
      check("data_byte", data_in, exp_b);
      data_strobe = 1'b1;
      @(negedge clk);
      data_strobe = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("valid_after_pkt", data_in_valid, 0);
    check("toggle", data_toggle, m_tog);
    check("sb_empty", sb_q.size(), 0);
    sb_q.delete();
    if (ack) begin
      success = 1'b1;
      @(negedge clk);
      success = 1'b0;
    end
    transaction_active = 1'b0;
    @(negedge clk);
    if (ack) begin
      m_sent += len;
      m_tog ^= 1;
      if (len == 0) m_zlp = 1'b0;
    end
    exp_done = ack && (m_sent == m_total) && !m_zlp;
    dut_done = done;
    check("done_pulse", done, exp_done);
    check("busy_after_txn", busy, !exp_done);
    @(negedge clk);
    check("done_clear", done, 0);
  endtask

  initial begin
    bit d;
    int n;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'((i * 37 + 11) & 255);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = 8'd0; req_len = 8'd0; desc_len = 8'd0;
    transaction_active = 1'b0; direction_in = 1'b0; data_strobe = 1'b0; success = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_data_in", data_in, 0);
    check("rst_valid", data_in_valid, 0);
    check("rst_toggle", data_toggle, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;

    vecs[0] = '{0, 64, 18, 3};     // device descriptor 8/8/2
    vecs[1] = '{0, 8, 18, 1};      // enumeration probe
    vecs[2] = '{18, 255, 16, 3};   // exact multiple: 8/8/ZLP
    vecs[3] = '{20, 16, 20, 2};    // exact multiple, no ZLP (total == req)
    vecs[4] = '{250, 10, 10, 2};   // address wrap
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].addr, vecs[v].req, vecs[v].desc);
      check("busy_after_start", busy, 1);
      d = 1'b0;
      n = 0;
      while (!d && n < 10) begin
        in_txn(1'b1, d);
        n++;
      end
      check("packet_count", n, vecs[v].exp_pkts);
    end

    // status-stage OUT after the probe finished leaves the block idle
    transaction_active = 1'b1; direction_in = 1'b0;
    repeat (3) @(negedge clk);
    transaction_active = 1'b0;
    @(negedge clk);
    check("out_idle_busy", busy, 0);
    check("out_idle_valid", data_in_valid, 0);

    // OUT token in ARMED ends the stage without a done pulse
    do_start(0, 64, 18);
    in_txn(1'b1, d);
    transaction_active = 1'b1; direction_in = 1'b0;
    @(negedge clk);
    check("status_out_busy", busy, 0);
    check("status_out_done", done, 0);
    transaction_active = 1'b0;
    @(negedge clk);

    // lost ACK on packet 2
    do_start(0, 64, 18);
    in_txn(1'b1, d);
    in_txn(1'b0, d);
    check("lost_ack_no_done", d, 0);
    in_txn(1'b1, d);
    in_txn(1'b1, d);
    check("lost_ack_done", d, 1);

    // abort at byte 3 of packet 1, then a fresh start at 43
    do_start(0, 64, 18);
    transaction_active = 1'b1; direction_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int w = 0;
      while (!data_in_valid && w < 12) begin
        @(negedge clk);
        w++;
      end
      check("abort_pre_byte", data_in, rom_mem[i]);
      if (i < 3) begin
        data_strobe = 1'b1;
        @(negedge clk);
        data_strobe = 1'b0;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", data_in_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_toggle", data_toggle, 1);
    transaction_active = 1'b0;
    @(negedge clk);
    do_start(43, 8, 8);
    in_txn(1'b1, d);
    check("restart_done", d, 1);

    // zero length request
    do_start(5, 0, 18);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_done_clear", done, 0);
    check("zero_valid", data_in_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
